// File: rtl/plate_char_segment.sv
// Character segmentation behind the plate locator: per-column ink projection inside the
// plate box, run splitting during vertical blanking, and a box/divider overlay on the video.
module plate_char_segment #(
    parameter int unsigned COL_W       = 512,
    parameter int unsigned MAX_CHAR    = 8,
    parameter int unsigned MIN_COL_CNT = 2,
    parameter int unsigned MIN_WIDTH   = 3,
    parameter logic [23:0] BOX_COLOR   = 24'hFF0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_hs,
    input  logic                     i_vs,
    input  logic                     i_de,
    input  logic [11:0]              i_x,
    input  logic [11:0]              i_y,
    input  logic [23:0]              i_data,
    input  logic                     i_th,
    input  logic [11:0]              edge_left,
    input  logic [11:0]              edge_right,
    input  logic [11:0]              edge_up,
    input  logic [11:0]              edge_dowm,
    output logic [23:0]              o_data,
    output logic                     o_hs,
    output logic                     o_vs,
    output logic                     o_de,
    output logic [3:0]               char_num,
    output logic [MAX_CHAR*24-1:0]   char_bound,
    output logic                     seg_valid
);

    localparam int unsigned AW    = $clog2(COL_W);
    localparam int unsigned WW    = AW + 1;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned XW    = 12;
    localparam int unsigned IW    = 4;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_ACCUM,
        S_SCAN,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic                    vs_q;
    logic [XW-1:0]           l_q, r_q, u_q, d_q;
    logic [WW-1:0]           w_q;
    logic                    skip_q;
    logic [AW-1:0]           clr_q;
    logic [AW-1:0]           k_q;
    logic                    in_run_q;
    logic [XW-1:0]           start_q;
    logic [IW-1:0]           idx_q;
    logic [23:0]             slot_q [MAX_CHAR];
    logic                    acc_valid_q;
    logic [AW-1:0]           acc_addr_q;
    logic [XW-1:0]           pub_l_q, pub_r_q, pub_u_q, pub_d_q;
    logic                    pub_valid_q;
    logic [IW-1:0]           char_num_q;
    logic [MAX_CHAR*24-1:0]  char_bound_q;
    logic                    seg_valid_q;
    logic [23:0]             o_data_q;
    logic                    o_hs_q, o_vs_q, o_de_q;

    logic [CNT_W-1:0]        proj_mem [COL_W];

    assign o_data     = o_data_q;
    assign o_hs       = o_hs_q;
    assign o_vs       = o_vs_q;
    assign o_de       = o_de_q;
    assign char_num   = char_num_q;
    assign char_bound = char_bound_q;
    assign seg_valid  = seg_valid_q;

    // Frame-start box capture
    logic          vs_rise_c;
    logic [XW-1:0] diff_c;
    logic [WW-1:0] w_c;

    assign vs_rise_c = i_vs && !vs_q;
    assign diff_c    = XW'(edge_right - edge_left);
    assign w_c       = (edge_right <= edge_left) ? '0 :
                       (diff_c > XW'(COL_W))     ? WW'(COL_W) : WW'(diff_c);

    // Accumulation: first stage qualifies the pixel and forms the column address
    logic          in_box_c;
    logic [XW-1:0] off_c;
    logic          acc_hit_c;
    logic [CNT_W-1:0] acc_rd_c;

    assign in_box_c  = (state_q == S_ACCUM) && i_vs && i_de && !skip_q &&
                       (i_x > l_q) && (i_x <= r_q) && (i_y > u_q) && (i_y <= d_q);
    assign off_c     = XW'(i_x - l_q - XW'(1));
    assign acc_hit_c = in_box_c && i_th && (off_c < XW'(w_q));
    assign acc_rd_c  = proj_mem[acc_addr_q];

    // Scan: run detection over the projection
    logic [CNT_W-1:0] scan_cnt_c;
    logic             ink_c;
    logic             last_c;
    logic [XW-1:0]    x_k_c;
    logic             run_close_c;
    logic [XW-1:0]    run_start_c;
    logic [XW-1:0]    run_end_c;
    logic             accept_c;

    assign scan_cnt_c  = proj_mem[k_q];
    assign ink_c       = scan_cnt_c >= CNT_W'(MIN_COL_CNT);
    assign last_c      = (WW'(k_q) == WW'(w_q - WW'(1)));
    assign x_k_c       = XW'(l_q + XW'(k_q) + XW'(1));
    assign run_close_c = (in_run_q && !ink_c) || (ink_c && last_c);
    assign run_start_c = (ink_c && !in_run_q) ? x_k_c : start_q;
    assign run_end_c   = (ink_c && last_c) ? XW'(l_q + XW'(w_q)) : XW'(l_q + XW'(k_q));
    assign accept_c    = (state_q == S_SCAN) && run_close_c &&
                         (XW'(run_end_c - run_start_c) >= XW'(MIN_WIDTH - 1)) &&
                         (idx_q < IW'(MAX_CHAR));

    // Single projection write port: clear, scan-clear, or accumulate
    logic             mem_we_c;
    logic [AW-1:0]    mem_waddr_c;
    logic [CNT_W-1:0] mem_wdata_c;

    always_comb begin
        mem_we_c    = 1'b0;
        mem_waddr_c = '0;
        mem_wdata_c = '0;
        case (state_q)
            S_CLEAR: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = clr_q;
            end
            S_SCAN: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = k_q;
            end
            default: begin
                if (acc_valid_q) begin
                    mem_we_c    = 1'b1;
                    mem_waddr_c = acc_addr_q;
                    mem_wdata_c = (acc_rd_c == '1) ? acc_rd_c : CNT_W'(acc_rd_c + CNT_W'(1));
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            proj_mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    // Overlay from the currently published box and bounds
    logic box_hit_c;
    logic char_hit_c;
    logic y_in_c;

    assign y_in_c    = (i_y >= pub_u_q) && (i_y <= pub_d_q);
    assign box_hit_c = pub_valid_q &&
                       ((((i_y == pub_u_q) || (i_y == pub_d_q)) && (i_x >= pub_l_q) && (i_x <= pub_r_q)) ||
                        (((i_x == pub_l_q) || (i_x == pub_r_q)) && y_in_c));

    always_comb begin
        char_hit_c = 1'b0;
        for (int i = 0; i < int'(MAX_CHAR); i++) begin
            if ((IW'(i) < char_num_q) && y_in_c &&
                ((i_x == char_bound_q[i*24+12 +: 12]) || (i_x == char_bound_q[i*24 +: 12]))) begin
                char_hit_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_CLEAR;
            vs_q         <= 1'b0;
            l_q          <= '0;
            r_q          <= '0;
            u_q          <= '0;
            d_q          <= '0;
            w_q          <= '0;
            skip_q       <= 1'b0;
            clr_q        <= '0;
            k_q          <= '0;
            in_run_q     <= 1'b0;
            start_q      <= '0;
            idx_q        <= '0;
            for (int i = 0; i < int'(MAX_CHAR); i++) slot_q[i] <= '0;
            acc_valid_q  <= 1'b0;
            acc_addr_q   <= '0;
            pub_l_q      <= '0;
            pub_r_q      <= '0;
            pub_u_q      <= '0;
            pub_d_q      <= '0;
            pub_valid_q  <= 1'b0;
            char_num_q   <= '0;
            char_bound_q <= '0;
            seg_valid_q  <= 1'b0;
            o_data_q     <= '0;
            o_hs_q       <= 1'b0;
            o_vs_q       <= 1'b0;
            o_de_q       <= 1'b0;
        end else begin
            vs_q        <= i_vs;
            o_hs_q      <= i_hs;
            o_vs_q      <= i_vs;
            o_de_q      <= i_de;
            o_data_q    <= (i_de && (box_hit_c || char_hit_c)) ? BOX_COLOR : i_data;
            acc_valid_q <= acc_hit_c;
            acc_addr_q  <= AW'(off_c);
            seg_valid_q <= 1'b0;

            case (state_q)
                S_CLEAR: begin
                    clr_q <= AW'(clr_q + AW'(1));
                    if (clr_q == AW'(COL_W - 1)) begin
                        state_q <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (vs_rise_c) begin
                        l_q      <= edge_left;
                        r_q      <= edge_right;
                        u_q      <= edge_up;
                        d_q      <= edge_dowm;
                        w_q      <= w_c;
                        skip_q   <= (edge_right <= edge_left) || (edge_dowm <= edge_up);
                        idx_q    <= '0;
                        k_q      <= '0;
                        in_run_q <= 1'b0;
                        for (int i = 0; i < int'(MAX_CHAR); i++) slot_q[i] <= '0;
                        state_q  <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (!i_vs) begin
                        state_q <= skip_q ? S_DONE : S_SCAN;
                    end
                end
                S_SCAN: begin
                    k_q      <= AW'(k_q + AW'(1));
                    in_run_q <= ink_c;
                    if (ink_c && !in_run_q) begin
                        start_q <= x_k_c;
                    end
                    if (accept_c) begin
                        for (int i = 0; i < int'(MAX_CHAR); i++) begin
                            if (idx_q == IW'(i)) slot_q[i] <= {run_start_c, run_end_c};
                        end
                        idx_q <= IW'(idx_q + IW'(1));
                    end
                    if (last_c) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    char_num_q <= idx_q;
                    for (int i = 0; i < int'(MAX_CHAR); i++) begin
                        char_bound_q[i*24 +: 24] <= slot_q[i];
                    end
                    seg_valid_q <= 1'b1;
                    pub_l_q     <= l_q;
                    pub_r_q     <= r_q;
                    pub_u_q     <= u_q;
                    pub_d_q     <= d_q;
                    pub_valid_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_plate_char_segment.sv
// Scoreboard bench for plate_char_segment: frames are driven pixel by pixel, expected
// segmentation results are queued per frame and popped on each seg_valid pulse.
module tb_plate_char_segment;

    localparam int MC = 8;
    localparam int BW = MC * 24;

    logic          clk;
    logic          rst;
    logic          i_hs, i_vs, i_de, i_th;
    logic [11:0]   i_x, i_y;
    logic [23:0]   i_data;
    logic [11:0]   edge_left, edge_right, edge_up, edge_dowm;
    logic [23:0]   o_data;
    logic          o_hs, o_vs, o_de;
    logic [3:0]    char_num;
    logic [BW-1:0] char_bound;
    logic          seg_valid;

    plate_char_segment dut (
        .clk        (clk),
        .rst        (rst),
        .i_hs       (i_hs),
        .i_vs       (i_vs),
        .i_de       (i_de),
        .i_x        (i_x),
        .i_y        (i_y),
        .i_data     (i_data),
        .i_th       (i_th),
        .edge_left  (edge_left),
        .edge_right (edge_right),
        .edge_up    (edge_up),
        .edge_dowm  (edge_dowm),
        .o_data     (o_data),
        .o_hs       (o_hs),
        .o_vs       (o_vs),
        .o_de       (o_de),
        .char_num   (char_num),
        .char_bound (char_bound),
        .seg_valid  (seg_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    num;
        logic [BW-1:0] bound;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_seg  = 0;
    int   exp_seg = 0;
    int   fgrows [0:1023];

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fg();
        for (int i = 0; i < 1024; i++) fgrows[i] = 0;
    endtask

    task automatic push_exp(input logic [3:0] num, input logic [BW-1:0] bound);
        exp_t e;
        e.num   = num;
        e.bound = bound;
        sb.push_back(e);
        exp_seg++;
    endtask

    // Foreground when the row lies within the first fgrows[x] rows below the top edge
    task automatic run_frame(input int l, input int r, input int u, input int d, input int blank_after);
        edge_left  = 12'(l);
        edge_right = 12'(r);
        edge_up    = 12'(u);
        edge_dowm  = 12'(d);
        i_vs = 1'b0; i_de = 1'b0; i_hs = 1'b0;
        repeat (4) tick();
        i_vs = 1'b1;
        for (int y = u - 1; y <= d + 1; y++) begin
            for (int x = l - 2; x <= r + 2; x++) begin
                i_de   = 1'b1;
                i_x    = 12'(x);
                i_y    = 12'(y);
                i_data = 24'(x);
                i_th   = (y > u) && ((y - u) <= fgrows[x]);
                tick();
            end
            i_de = 1'b0; i_th = 1'b0; i_hs = 1'b1;
            repeat (2) tick();
            i_hs = 1'b0;
        end
        i_vs = 1'b0;
        repeat (blank_after) tick();
    endtask

    task automatic wait_seg(input int target);
        for (int c = 0; c < 3000 && n_seg < target; c++) tick();
        chk("seg_wait", BW'(n_seg >= target), BW'(1));
    endtask

    task automatic pix(input int x, input int y, input logic [23:0] data, input logic [23:0] exp, input string tag);
        i_de = 1'b1; i_x = 12'(x); i_y = 12'(y); i_data = data;
        tick();
        chk(tag, BW'(o_data), BW'(exp));
    endtask

    always @(negedge clk) begin
        if (seg_valid) begin
            n_seg++;
            if (sb.size() == 0) begin
                chk("seg_unexpected", BW'(1), BW'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("char_num", BW'(char_num), BW'(e.num));
                chk("char_bound", char_bound, e.bound);
            end
        end
    end

    initial begin
        logic [BW-1:0] eb;
        rst = 1'b1;
        i_hs = 0; i_vs = 0; i_de = 0; i_th = 0;
        i_x = 0; i_y = 0; i_data = 0;
        edge_left = 0; edge_right = 0; edge_up = 0; edge_dowm = 0;
        clear_fg();
        repeat (3) tick();
        chk("rst_o_data", BW'(o_data), BW'(0));
        chk("rst_char_num", BW'(char_num), BW'(0));
        chk("rst_char_bound", char_bound, BW'(0));
        chk("rst_seg_valid", BW'(seg_valid), BW'(0));
        chk("rst_o_ctrl", BW'({o_hs, o_vs, o_de}), BW'(0));
        rst = 1'b0;

        // Frame during CLEAR must be ignored entirely
        repeat (10) tick();
        edge_left = 12'd100; edge_right = 12'd180; edge_up = 12'd80; edge_dowm = 12'd120;
        i_vs = 1'b1;
        repeat (20) tick();
        i_vs = 1'b0;
        repeat (600) tick();
        chk("clear_no_seg", BW'(n_seg), BW'(0));

        // Two accepted characters, 2-wide run rejected, ink at x==L excluded
        clear_fg();
        for (int x = 110; x <= 119; x++) fgrows[x] = 1000;
        for (int x = 130; x <= 131; x++) fgrows[x] = 1000;
        for (int x = 150; x <= 170; x++) fgrows[x] = 1000;
        fgrows[100] = 1000;
        eb = '0;
        eb[0 +: 24]  = {12'd110, 12'd119};
        eb[24 +: 24] = {12'd150, 12'd170};
        push_exp(4'd2, eb);
        run_frame(100, 180, 80, 120, 4);
        wait_seg(exp_seg);

        // Overlay from the published results
        i_hs = 0; i_vs = 0; i_de = 0;
        tick();
        pix(110, 100, 24'h123456, 24'hFF0000, "ovl_char_left");
        pix(111, 100, 24'h123456, 24'h123456, "ovl_plain");
        pix(140, 80,  24'h0000AA, 24'hFF0000, "ovl_top_edge");
        pix(140, 79,  24'h0000AA, 24'h0000AA, "ovl_above_box");
        pix(180, 110, 24'h00BB00, 24'hFF0000, "ovl_right_edge");
        i_de = 1'b0;
        tick();
        // Timing lag; the single-cycle vs pulse also starts an empty frame
        push_exp(4'd0, BW'(0));
        i_hs = 1'b1; i_vs = 1'b1; i_de = 1'b1; i_x = 12'd5; i_y = 12'd5; i_data = 24'hAAAAAA;
        #2;
        chk("lag_before", BW'({o_hs, o_vs, o_de}), BW'(0));
        tick();
        chk("lag_after", BW'({o_hs, o_vs, o_de}), BW'(3'b111));
        chk("lag_data", BW'(o_data), BW'(24'hAAAAAA));
        i_hs = 1'b0; i_vs = 1'b0; i_de = 1'b0;
        tick();
        chk("lag_fall", BW'({o_hs, o_vs, o_de}), BW'(0));
        wait_seg(exp_seg);

        // Threshold: 2-pixel columns are ink, 1-pixel columns are not; then a frame
        // starting during SCAN is dropped
        clear_fg();
        for (int x = 205; x <= 208; x++) fgrows[x] = 2;
        for (int x = 215; x <= 218; x++) fgrows[x] = 1;
        eb = '0;
        eb[0 +: 24] = {12'd205, 12'd208};
        push_exp(4'd1, eb);
        run_frame(200, 230, 50, 60, 0);
        clear_fg();
        for (int x = 60; x <= 70; x++) fgrows[x] = 1000;
        run_frame(50, 80, 20, 25, 4);
        wait_seg(exp_seg);
        repeat (100) tick();
        chk("dropped_frame", BW'(n_seg), BW'(exp_seg));

        // Ink touching the right edge closes at the last column
        clear_fg();
        for (int x = 175; x <= 185; x++) fgrows[x] = 1000;
        eb = '0;
        eb[0 +: 24] = {12'd175, 12'd180};
        push_exp(4'd1, eb);
        run_frame(100, 180, 80, 84, 4);
        wait_seg(exp_seg);

        // Degenerate box R==L: nothing reported, pulse still produced
        push_exp(4'd0, BW'(0));
        run_frame(50, 50, 10, 14, 4);
        wait_seg(exp_seg);

        // Ten 4-wide runs: only the first eight reported
        clear_fg();
        eb = '0;
        for (int i = 0; i < 10; i++) begin
            for (int x = 22 + 6 * i; x <= 25 + 6 * i; x++) fgrows[x] = 1000;
            if (i < MC) eb[i*24 +: 24] = {12'(22 + 6 * i), 12'(25 + 6 * i)};
        end
        push_exp(4'd8, eb);
        run_frame(20, 90, 10, 13, 4);
        wait_seg(exp_seg);

        // Reset mid-frame clears published outputs at once
        i_vs = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        #2;
        chk("midrst_char_num", BW'(char_num), BW'(0));
        chk("midrst_char_bound", char_bound, BW'(0));
        chk("midrst_o_data", BW'(o_data), BW'(0));
        i_vs = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        chk("sb_empty", BW'(sb.size()), BW'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
